// File: rtl/ncobs_pkg.sv
// Shared types and constants for the nested-COBS trace encoder.
package ncobs_pkg;

  typedef logic [7:0] LevelT;
  typedef logic [7:0] RunT;
  typedef logic [1:0] StateT;

  // FSM encoding
  localparam StateT IDLE  = 2'd0;
  localparam StateT CLOSE = 2'd1;
  localparam StateT OPEN  = 2'd2;

  localparam logic [7:0] COBS_DELIM = 8'h00;
  localparam logic [7:0] COBS_SPLIT = 8'hFF;

  // Code byte that terminates a run of 'run' non-zero bytes; never 0x00.
  function automatic RunT code_of(input RunT run);
    return run + 8'd1;
  endfunction

endpackage

// File: rtl/ncobs_lane_encoder.sv
// Combinational trailing-code COBS encoder for up to N bytes.
// Bytes beyond in_count are ignored; a run that reaches MAX_RUN after a
// non-zero byte gets a 0xFF split inserted right after that byte.
module ncobs_lane_encoder
  import ncobs_pkg::*;
#(
  parameter int N       = 4,
  parameter int MAX_RUN = 254
) (
  input  logic [N*8-1:0]           in_data,
  input  logic [$clog2(N+1)-1:0]   in_count,
  input  RunT                      run_in,
  output logic [(N+1)*8-1:0]       enc_data,
  output logic [$clog2(N+2)-1:0]   enc_width,
  output RunT                      run_out
);

  localparam int PW = $clog2(N+2);

  logic [PW-1:0] pos;
  RunT           run_v;
  logic [7:0]    byte_v;

  // Walk the lanes in stream order, packing output bytes from lane 0 up.
  always_comb begin
    pos      = '0;
    run_v    = run_in;
    byte_v   = '0;
    enc_data = '0;
    for (int i = 0; i < N; i++) begin
      if (i < int'(in_count)) begin
        byte_v = in_data[i*8 +: 8];
        if (byte_v == COBS_DELIM) begin
          enc_data[int'(pos)*8 +: 8] = code_of(run_v);
          run_v = '0;
          pos   = pos + PW'(1);
        end else begin
          enc_data[int'(pos)*8 +: 8] = byte_v;
          run_v = run_v + 8'd1;
          pos   = pos + PW'(1);
          if (run_v == RunT'(MAX_RUN)) begin
            enc_data[int'(pos)*8 +: 8] = COBS_SPLIT;
            run_v = '0;
            pos   = pos + PW'(1);
          end
        end
      end
    end
    enc_width = pos;
    run_out   = run_v;
  end

endmodule

// File: rtl/n_cobs_encoder_wide.sv
// Multi-lane nested-COBS trace encoder: one COBS run per priority level,
// preemption opens a nested frame, returning levels close them.
// Optional feature macro: NCOBS_TIMESTAMP_EN (frame open emits timer_i).
module n_cobs_encoder_wide
  import ncobs_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int PRIO_NUM    = 4,
  parameter int TIMER_BYTES = 3,
  parameter int OUT_BYTES   = LANES + 1,
  parameter int MAX_RUN     = 254
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [TIMER_BYTES*8-1:0]       timer_i,
  input  logic [$clog2(PRIO_NUM)-1:0]    level_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [LANES*8-1:0]             in_data_i,
  input  logic [$clog2(LANES+1)-1:0]     in_bytes_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [OUT_BYTES*8-1:0]         out_data_o,
  output logic [$clog2(OUT_BYTES+1)-1:0] out_width_o
);

  localparam int LW  = $clog2(PRIO_NUM);
  localparam int OW  = $clog2(OUT_BYTES+1);
  localparam int OB8 = OUT_BYTES*8;

  StateT                 state_reg, state_next;
  logic [LW-1:0]         cur_level_reg, cur_level_next;
  logic [LW-1:0]         k_reg, k_next, k_inc;
  RunT                   run_reg  [PRIO_NUM];
  RunT                   run_next [PRIO_NUM];
  logic [PRIO_NUM-1:0]   open_reg, open_next;
  logic                  out_valid_reg;
  logic [OB8-1:0]        out_data_reg;
  logic [OW-1:0]         out_width_reg;

  logic                  beat_valid;
  logic [OB8-1:0]        beat_data;
  logic [OW-1:0]         beat_width;
  logic                  adv;

  logic [(LANES+1)*8-1:0]     pay_data;
  logic [$clog2(LANES+2)-1:0] pay_width;
  RunT                        pay_run;

  assign adv        = !out_valid_reg || out_ready_i;
  assign in_ready_o = (state_reg == IDLE) && (level_i == cur_level_reg) && adv;
  assign k_inc      = k_reg + LW'(1);

  ncobs_lane_encoder #(.N(LANES), .MAX_RUN(MAX_RUN)) u_pay_enc (
    .in_data   (in_data_i),
    .in_count  (in_bytes_i),
    .run_in    (run_reg[cur_level_reg]),
    .enc_data  (pay_data),
    .enc_width (pay_width),
    .run_out   (pay_run)
  );

`ifdef NCOBS_TIMESTAMP_EN
  localparam int TCW = $clog2(TIMER_BYTES+1);

  logic [TIMER_BYTES*8-1:0]       timer_msb;
  logic [(TIMER_BYTES+1)*8-1:0]   tim_data;
  logic [$clog2(TIMER_BYTES+2)-1:0] tim_width;
  RunT                            tim_run;

  // Timestamp goes out MSB first, so reverse the byte order into lanes.
  for (genvar gi = 0; gi < TIMER_BYTES; gi++) begin : g_timer_msb
    assign timer_msb[gi*8 +: 8] = timer_i[(TIMER_BYTES-1-gi)*8 +: 8];
  end

  // The fresh frame starts from run 0, so the timer is encoded from there.
  ncobs_lane_encoder #(.N(TIMER_BYTES), .MAX_RUN(MAX_RUN)) u_tim_enc (
    .in_data   (timer_msb),
    .in_count  (TCW'(TIMER_BYTES)),
    .run_in    ('0),
    .enc_data  (tim_data),
    .enc_width (tim_width),
    .run_out   (tim_run)
  );
`else
  logic unused_timer;
  assign unused_timer = ^timer_i;
`endif

  // Next-state and output-beat selection; nothing moves unless the out stage can advance.
  always_comb begin
    state_next     = state_reg;
    cur_level_next = cur_level_reg;
    k_next         = k_reg;
    open_next      = open_reg;
    for (int p = 0; p < PRIO_NUM; p++) run_next[p] = run_reg[p];
    beat_valid     = 1'b0;
    beat_data      = '0;
    beat_width     = '0;
    if (adv) begin
      case (state_reg)
        IDLE: begin
          if (level_i > cur_level_reg) begin
            state_next = CLOSE;
            k_next     = cur_level_reg;
          end else if (level_i < cur_level_reg) begin
            state_next = OPEN;
          end else if (in_valid_i) begin
            beat_valid              = 1'b1;
            beat_data               = OB8'(pay_data);
            beat_width              = OW'(pay_width);
            run_next[cur_level_reg] = pay_run;
          end
        end
        CLOSE: begin
          // The lowest-priority frame is permanent and is never closed.
          if (open_reg[k_reg] && (k_reg != LW'(PRIO_NUM-1))) begin
            beat_valid       = 1'b1;
            beat_data[7:0]   = code_of(run_reg[k_reg]);
            beat_data[15:8]  = COBS_DELIM;
            beat_width       = OW'(2);
            open_next[k_reg] = 1'b0;
            run_next[k_reg]  = '0;
          end
          k_next = k_inc;
          // Stop once the walk reaches the target; a target that moved up
          // meanwhile is picked up as a push from IDLE.
          if ((k_inc >= level_i) || (k_inc == LW'(PRIO_NUM-1))) begin
            cur_level_next = k_inc;
            state_next     = IDLE;
          end
        end
        OPEN: begin
          if (level_i < cur_level_reg) begin
`ifdef NCOBS_TIMESTAMP_EN
            beat_valid        = 1'b1;
            beat_data         = OB8'(tim_data);
            beat_width        = OW'(tim_width);
            run_next[level_i] = tim_run;
`else
            run_next[level_i] = '0;
`endif
            open_next[level_i] = 1'b1;
            cur_level_next     = level_i;
          end
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Control state and per-level runs; reset restores the single permanent frame.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg     <= IDLE;
      cur_level_reg <= LW'(PRIO_NUM-1);
      k_reg         <= '0;
      open_reg      <= {1'b1, {(PRIO_NUM-1){1'b0}}};
      for (int p = 0; p < PRIO_NUM; p++) run_reg[p] <= '0;
    end else begin
      state_reg     <= state_next;
      cur_level_reg <= cur_level_next;
      k_reg         <= k_next;
      open_reg      <= open_next;
      for (int p = 0; p < PRIO_NUM; p++) run_reg[p] <= run_next[p];
    end
  end

  // Single output stage; holds its beat while the FIFO stalls.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_width_reg <= '0;
    end else if (adv) begin
      out_valid_reg <= beat_valid;
      out_data_reg  <= beat_data;
      out_width_reg <= beat_width;
    end
  end

  assign out_valid_o = out_valid_reg;
  assign out_data_o  = out_data_reg;
  assign out_width_o = out_width_reg;

endmodule

// File: tb/tb_n_cobs_encoder_wide.sv
// Scoreboard bench for n_cobs_encoder_wide (LANES=4, PRIO_NUM=4, TIMER_BYTES=3).
// Expected beats come from a byte-level model of the nested COBS rules.
module tb_n_cobs_encoder_wide;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [23:0] timer_i;
  logic [1:0]  level_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_data_i;
  logic [2:0]  in_bytes_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [39:0] out_data_o;
  logic [2:0]  out_width_o;

  always #5 clk_i = ~clk_i;

  n_cobs_encoder_wide #(.LANES(4), .PRIO_NUM(4), .TIMER_BYTES(3)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .timer_i     (timer_i),
    .level_i     (level_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_bytes_i  (in_bytes_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_width_o (out_width_o)
  );

  typedef struct {
    logic [39:0] data;
    int          width;
  } beat_t;

  int         checks = 0;
  int         errors = 0;
  beat_t      exp_q[$];
  logic [7:0] bq[$];
  int         m_cur;
  int         m_run[4];
  bit         m_open[4];
  int         bp_mode = 0;   // 0: always ready, 1: random, 2: held low
  bit         abort = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_cur = 3;
    for (int i = 0; i < 4; i++) begin
      m_run[i]  = 0;
      m_open[i] = (i == 3);
    end
    bq.delete();
  endtask

  // One payload byte through the stream of level lvl.
  task automatic model_byte(input int lvl, input logic [7:0] b);
    if (b == 8'h00) begin
      bq.push_back(8'(m_run[lvl] + 1));
      m_run[lvl] = 0;
    end else begin
      bq.push_back(b);
      m_run[lvl]++;
      if (m_run[lvl] == 254) begin
        bq.push_back(8'hFF);
        m_run[lvl] = 0;
      end
    end
  endtask

  task automatic finish_beat();
    beat_t b;
    b.data  = '0;
    b.width = bq.size();
    for (int i = 0; i < bq.size(); i++) b.data[i*8 +: 8] = bq[i];
    if (bq.size() != 0) exp_q.push_back(b);
    bq.delete();
  endtask

  task automatic model_level(input int lv, input logic [23:0] tmr);
    if (lv > m_cur) begin
      for (int k = m_cur; k < lv; k++) begin
        if (m_open[k] && k != 3) begin
          bq.push_back(8'(m_run[k] + 1));
          bq.push_back(8'h00);
          finish_beat();
          m_open[k] = 0;
          m_run[k]  = 0;
        end
      end
    end else if (lv < m_cur) begin
      m_run[lv] = 0;
`ifdef NCOBS_TIMESTAMP_EN
      model_byte(lv, tmr[23:16]);
      model_byte(lv, tmr[15:8]);
      model_byte(lv, tmr[7:0]);
      finish_beat();
`endif
      m_open[lv] = 1;
    end
    m_cur = lv;
  endtask

  // Back-pressure driver.
  initial begin
    out_ready_i = 1'b1;
    forever begin
      @(negedge clk_i);
      out_ready_i = (bp_mode == 0) ? 1'b1 :
                    (bp_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard on every accepted beat, checks hold while stalled.
  initial begin : monitor
    logic [39:0] prev_d;
    logic [2:0]  prev_w;
    bit          stalled;
    logic [63:0] mask;
    beat_t       e;
    stalled = 0;
    prev_d  = '0;
    prev_w  = '0;
    forever begin
      @(negedge clk_i);
      #4;
      if (reset_i) begin
        stalled = 0;
      end else begin
        if (stalled) begin
          chk("stall_hold", {out_valid_o, out_width_o, out_data_o}, {1'b1, prev_w, prev_d});
        end
        if (out_valid_o && out_ready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual=%0h width=%0d required=none", out_data_o, out_width_o);
          end else begin
            e    = exp_q.pop_front();
            mask = (64'h1 << (e.width * 8)) - 64'h1;
            $display("beat width=%0d data=%0h expected=%0h", out_width_o, out_data_o, e.data);
            chk("beat_width", 64'(out_width_o), 64'(e.width));
            chk("beat_data", 64'(out_data_o) & mask, 64'(e.data) & mask);
          end
        end
        stalled = out_valid_o && !out_ready_i;
        prev_d  = out_data_o;
        prev_w  = out_width_o;
      end
    end
  end

  task automatic send(input logic [31:0] d, input int n);
    bit fire;
    int cyc;
    if (abort) return;
    for (int i = 0; i < n; i++) model_byte(m_cur, d[i*8 +: 8]);
    finish_beat();
    @(negedge clk_i);
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_bytes_i = 3'(n);
    fire = 0;
    cyc  = 0;
    while (!fire && cyc < 200) begin
      #4;
      fire = in_ready_o;
      @(posedge clk_i);
      cyc++;
      if (!fire) @(negedge clk_i);
    end
    if (!fire) begin
      chk("in_accept_timeout", 64'd0, 64'd1);
      abort = 1;
    end
    @(negedge clk_i);
    in_valid_i = 1'b0;
  endtask

  task automatic set_level(input int lv, input logic [23:0] tmr);
    bit done;
    if (abort) return;
    model_level(lv, tmr);
    @(negedge clk_i);
    level_i = 2'(lv);
    timer_i = tmr;
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      #4;
      if (in_ready_o) done = 1;
      else @(negedge clk_i);
    end
    if (!done) begin
      chk("level_settle_timeout", 64'd0, 64'd1);
      abort = 1;
    end
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk_i);
      #4;
      if (exp_q.size() == 0) done = 1;
    end
    if (!done) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      abort = 1;
    end
  endtask

  function automatic logic [7:0] rnd_byte();
    return ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
  endfunction

  initial begin : main
    logic [31:0] d;
    logic [39:0] snap;
    bit          seen;
    int          op;
    reset_i    = 1'b1;
    timer_i    = '0;
    level_i    = 2'd3;
    in_valid_i = 1'b0;
    in_data_i  = '0;
    in_bytes_i = 3'd1;
    model_reset();
    repeat (3) @(negedge clk_i);
    #4;
    chk("reset_out_valid", 64'(out_valid_o), 64'd0);
    chk("reset_out_width", 64'(out_width_o), 64'd0);
    chk("reset_out_data", 64'(out_data_o), 64'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    #4;
    chk("reset_in_ready_lvl3", 64'(in_ready_o), 64'd1);
    chk("reset_out_valid_after", 64'(out_valid_o), 64'd0);

    // Basic payload, nested open/close, multi-level pop.
    send(32'h3322_0011, 4);
    set_level(1, 24'h00AB00);
    set_level(3, 24'h123456);
    send(32'h0000_0044, 1);
    set_level(1, 24'h010203);
    set_level(0, 24'hC0FFEE);
    set_level(3, 24'h000000);
    drain();

    // Forced split: zero the run, then exactly 254 non-zero bytes.
    send(32'h0000_0000, 1);
    for (int i = 0; i < 63; i++) send(32'h5A5A_5A5A, 4);
    send(32'h0000_5A5A, 2);
    send(32'h0000_0000, 1);
    drain();

    // Randomized traffic with back-pressure.
    bp_mode = 1;
    for (int t = 0; t < 300 && !abort; t++) begin
      op = $urandom_range(0, 99);
      if (op < 20) begin
        set_level($urandom_range(0, 3), 24'($urandom));
      end else if (op < 23) begin
        for (int j = 0; j < 70; j++) send(32'($urandom) | 32'h0101_0101, 4);
      end else begin
        d = {rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()};
        send(d, $urandom_range(1, 4));
      end
    end
    bp_mode = 0;
    set_level(3, 24'h0);
    drain();

    // Stall with a close beat pending, then reset in the middle of CLOSE.
    set_level(1, 24'h0A0B0C);
    set_level(0, 24'h0D0E0F);
    drain();
    bp_mode = 2;
    @(negedge clk_i);
    level_i = 2'd3;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #4;
      if (out_valid_o) seen = 1;
      else @(negedge clk_i);
    end
    chk("stall_beat_present", 64'(seen), 64'd1);
    snap = out_data_o;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      #4;
      chk("stall_data_held", 64'(out_data_o), 64'(snap));
      chk("stall_in_ready_low", 64'(in_ready_o), 64'd0);
    end
    @(negedge clk_i);
    #2;
    reset_i = 1'b1;
    #1;
    chk("async_reset_valid", 64'(out_valid_o), 64'd0);
    chk("async_reset_data", 64'(out_data_o), 64'd0);
    chk("async_reset_width", 64'(out_width_o), 64'd0);
    exp_q.delete();
    model_reset();
    bp_mode = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    #4;
    chk("post_reset_in_ready", 64'(in_ready_o), 64'd1);
    send(32'h0000_0000, 1);
    send(32'h0000_7700, 2);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog actual=running required=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
